// File: rtl/tt_um_cnt_checker.sv
// tt_um_cnt_checker
//   Watches a free-running 8-bit counter on ui_in and checks that every
//   sampled value is exactly one more (mod 256) than the previous sample.
//   Errors are counted (saturating), the last bad value is remembered, and a
//   small FSM tracks sync state: UNSYNC -> LOCKED, and LOCKED -> SLIP on a
//   mismatch. SLIP returns to LOCKED after LOCK_N consecutive good samples.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   ena     in   fabric enable; gates all state updates and all outputs
//   ui_in   in   [7:0] observed counter value
//   uio_in  in   [0] SAMPLE, [1] RESYNC, [2] OE, [3] SEL, [7:4] unused
//   uo_out  out  [7:0] SEL=0: error count, SEL=1: last mismatching value
//   uio_out out  [7] locked, [6] slip, [5] unsynced, [4] err_pulse, [3:0] 0
//   uio_oe  out  [7:4] = {4{OE}} while enabled, [3:0] always 0
module tt_um_cnt_checker #(
    parameter int LOCK_N = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_LOCKED = 2'd1,
        ST_SLIP   = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_N_4 = 4'(LOCK_N);

    // Saturating increment for the error counter: sticks at 0xFF.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    logic sample;
    logic resync;
    logic oe;
    logic sel;

    assign sample = uio_in[0];
    assign resync = uio_in[1];
    assign oe     = uio_in[2];
    assign sel    = uio_in[3];

    // Upper control bits carry no function.
    logic unused_uio_hi;
    assign unused_uio_hi = &{1'b0, uio_in[7:4]};

    state_t     state_q,    state_d;
    logic [7:0] expected_q, expected_d;
    logic [7:0] err_cnt_q,  err_cnt_d;
    logic [7:0] last_bad_q, last_bad_d;
    logic [3:0] good_run_q, good_run_d;
    logic       err_pulse_q, err_pulse_d;

    logic [7:0] bus_next;
    logic       match;
    logic [3:0] run_inc;

    assign bus_next = ui_in + 8'd1;
    assign match    = (ui_in == expected_q);
    assign run_inc  = good_run_q + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_UNSYNC;
            expected_q  <= 8'h00;
            err_cnt_q   <= 8'h00;
            last_bad_q  <= 8'h00;
            good_run_q  <= 4'd0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            err_cnt_q   <= err_cnt_d;
            last_bad_q  <= last_bad_d;
            good_run_q  <= good_run_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        err_cnt_d   = err_cnt_q;
        last_bad_d  = last_bad_q;
        good_run_d  = good_run_q;
        err_pulse_d = err_pulse_q;

        if (ena) begin
            // err_pulse only survives an edge that itself detects a mismatch.
            err_pulse_d = 1'b0;
            if (resync) begin
                // RESYNC wins over a simultaneous SAMPLE and never counts an error.
                expected_d = bus_next;
                state_d    = ST_LOCKED;
                good_run_d = 4'd0;
            end else if (sample) begin
                expected_d = bus_next;
                case (state_q)
                    ST_UNSYNC: begin
                        state_d = ST_LOCKED;
                    end
                    ST_LOCKED, ST_SLIP: begin
                        if (!match) begin
                            err_cnt_d   = sat_inc8(err_cnt_q);
                            last_bad_d  = ui_in;
                            good_run_d  = 4'd0;
                            state_d     = ST_SLIP;
                            err_pulse_d = 1'b1;
                        end else if (state_q == ST_SLIP) begin
                            if (run_inc == LOCK_N_4) begin
                                state_d    = ST_LOCKED;
                                good_run_d = 4'd0;
                            end else begin
                                good_run_d = run_inc;
                            end
                        end
                    end
                    default: begin
                        state_d = ST_UNSYNC;
                    end
                endcase
            end
        end
    end

    assign uo_out  = ena ? (sel ? last_bad_q : err_cnt_q) : 8'h00;
    assign uio_out = ena ? {(state_q == ST_LOCKED), (state_q == ST_SLIP),
                            (state_q == ST_UNSYNC), err_pulse_q, 4'b0000}
                         : 8'h00;
    assign uio_oe  = ena ? {{4{oe}}, 4'b0000} : 8'h00;

endmodule

// File: tb/tb_tt_um_cnt_checker.sv
// Scoreboard bench for tt_um_cnt_checker (LOCK_N = 4).
// Each stimulus step drives inputs for one clock edge and queues the
// hand-computed outputs expected after that edge; an independent monitor
// pops and compares shortly after each rising edge.
module tb_tt_um_cnt_checker;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_cnt_checker #(.LOCK_N(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control encodings for uio_in
    localparam logic [7:0] S   = 8'h01;
    localparam logic [7:0] R   = 8'h02;
    localparam logic [7:0] OE  = 8'h04;
    localparam logic [7:0] SEL = 8'h08;

    typedef struct {
        string      name;
        logic [7:0] uo;
        logic [7:0] uio;
        logic [7:0] oe;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    // Drive one edge's worth of inputs, then queue the expected outputs.
    // Inputs stay stable until 4 time units after the edge so the monitor
    // (at edge+2) sees the same SEL/OE/ena that the expectation assumes.
    task automatic step(input string nm, input logic e, input logic r,
                        input logic [7:0] ui, input logic [7:0] ctl,
                        input logic [7:0] xuo, input logic [7:0] xuio,
                        input logic [7:0] xoe);
        exp_t x;
        ena    = e;
        rst    = r;
        ui_in  = ui;
        uio_in = ctl;
        @(posedge clk);
        #1;
        x.name = nm;
        x.uo   = xuo;
        x.uio  = xuio;
        x.oe   = xoe;
        q.push_back(x);
        #3;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                n_chk++;
                if (uo_out === e.uo && uio_out === e.uio && uio_oe === e.oe) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got uo=%h uio_out=%h uio_oe=%h, want uo=%h uio_out=%h uio_oe=%h",
                             e.name, uo_out, uio_out, uio_oe, e.uo, e.uio, e.oe);
                end
            end
        end
    end

    initial begin
        logic [7:0] xe;
        rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;

        // Reset state
        step("reset_outputs",  1, 1, 8'h00, OE,  8'h00, 8'h20, 8'hF0);
        step("reset_sel_bad",  1, 1, 8'h00, OE|SEL, 8'h00, 8'h20, 8'hF0);
        step("idle_unsync",    1, 0, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00);

        // Lock and track
        step("lock_10",        1, 0, 8'h10, S|OE, 8'h00, 8'h80, 8'hF0);
        step("track_11",       1, 0, 8'h11, S|OE, 8'h00, 8'h80, 8'hF0);
        step("track_12",       1, 0, 8'h12, S|OE, 8'h00, 8'h80, 8'hF0);

        // Wrap-around
        step("resync_FE",      1, 0, 8'hFE, R|OE, 8'h00, 8'h80, 8'hF0);
        step("wrap_FF",        1, 0, 8'hFF, S|OE, 8'h00, 8'h80, 8'hF0);
        step("wrap_00",        1, 0, 8'h00, S|OE, 8'h00, 8'h80, 8'hF0);
        step("wrap_01",        1, 0, 8'h01, S|OE, 8'h00, 8'h80, 8'hF0);

        // Slip and relock
        step("resync_20",      1, 0, 8'h20, R|OE, 8'h00, 8'h80, 8'hF0);
        step("mismatch_25",    1, 0, 8'h25, S|OE, 8'h01, 8'h50, 8'hF0);
        step("slip_26_last",   1, 0, 8'h26, S|OE|SEL, 8'h25, 8'h40, 8'hF0);
        step("slip_27",        1, 0, 8'h27, S|OE|SEL, 8'h25, 8'h40, 8'hF0);
        step("slip_28",        1, 0, 8'h28, S|OE|SEL, 8'h25, 8'h40, 8'hF0);
        step("relock_29",      1, 0, 8'h29, S|OE|SEL, 8'h25, 8'h80, 8'hF0);
        step("locked_2A",      1, 0, 8'h2A, S|OE, 8'h01, 8'h80, 8'hF0);

        // Repeated values are mismatches; back-to-back keeps the pulse high
        step("repeat_2A",      1, 0, 8'h2A, S|OE, 8'h02, 8'h50, 8'hF0);
        step("repeat_2A_again",1, 0, 8'h2A, S|OE, 8'h03, 8'h50, 8'hF0);
        step("pulse_clears",   1, 0, 8'h2A, OE,   8'h03, 8'h40, 8'hF0);

        // Good run restarts after a mismatch inside SLIP
        step("slip_good_2B",   1, 0, 8'h2B, S|OE, 8'h03, 8'h40, 8'hF0);
        step("slip_good_2C",   1, 0, 8'h2C, S|OE, 8'h03, 8'h40, 8'hF0);
        step("slip_good_2D",   1, 0, 8'h2D, S|OE, 8'h03, 8'h40, 8'hF0);
        step("slip_bad_50",    1, 0, 8'h50, S|OE, 8'h04, 8'h50, 8'hF0);
        step("slip_run_51",    1, 0, 8'h51, S|OE, 8'h04, 8'h40, 8'hF0);

        // RESYNC wins over SAMPLE
        step("resync_32",      1, 0, 8'h32, R|OE, 8'h04, 8'h80, 8'hF0);
        step("resync_sample_40",1,0, 8'h40, R|S|OE, 8'h04, 8'h80, 8'hF0);
        step("match_41",       1, 0, 8'h41, S|OE, 8'h04, 8'h80, 8'hF0);

        // Enable and OE gating
        step("ena0_sample_a",  0, 0, 8'h99, S|OE, 8'h00, 8'h00, 8'h00);
        step("ena0_sample_b",  0, 0, 8'h13, S|OE|SEL, 8'h00, 8'h00, 8'h00);
        step("ena1_held_42",   1, 0, 8'h42, S|OE, 8'h04, 8'h80, 8'hF0);
        step("oe_off_43",      1, 0, 8'h43, S,    8'h04, 8'h80, 8'h00);

        // Saturation: 260 mismatches with the bus stuck at 0x00
        for (int i = 1; i <= 260; i++) begin
            xe = (4 + i > 255) ? 8'hFF : 8'(4 + i);
            step("saturate", 1, 0, 8'h00, S|OE, xe, 8'h50, 8'hF0);
        end
        step("sat_last_bad_07",1, 0, 8'h07, S|OE|SEL, 8'h07, 8'h50, 8'hF0);
        step("sat_hold_FF",    1, 0, 8'h07, OE,   8'hFF, 8'h40, 8'hF0);

        // Mid-stream reset, then a clean first sample
        step("midreset",       1, 1, 8'h55, OE,     8'h00, 8'h20, 8'hF0);
        step("midreset_sel",   1, 1, 8'h55, OE|SEL, 8'h00, 8'h20, 8'hF0);
        step("after_reset_77", 1, 0, 8'h77, S|OE,   8'h00, 8'h80, 8'hF0);
        step("after_reset_79", 1, 0, 8'h79, S|OE,   8'h01, 8'h50, 8'hF0);

        repeat (3) @(posedge clk);
        #3;
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
